// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, imem request issue and {pc, instr} FIFO feeding decode.
// Define FETCH_PERF_EN to add the flush_count performance counter output.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] branch_target
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           flush_count
`endif
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] pc, tag_pc;
    logic inflight, epoch, tag_epoch, push, pop, fire;
    logic [DATA_WIDTH-1:0] mem_instr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc [QUEUE_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0] count;
    // credit counts the in-flight response so a full queue never receives data
    assign imem_req = !rst && !PCsrc && (count + CW'(inflight)) < CW'(QUEUE_DEPTH);
    assign imem_addr = pc;
    assign fire = imem_req && imem_gnt;
    assign instr_valid = count != '0;
    assign pop = instr_valid && instr_ready;
    assign push = inflight && tag_epoch == epoch;
    assign rd_next = rd_ptr + AW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            tag_pc <= '0;
            inflight <= 1'b0;
            epoch <= 1'b0;
            tag_epoch <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            instr <= '0;
            instr_pc <= '0;
        end else begin
            inflight <= fire;
            if (fire) begin
                pc <= pc + DATA_WIDTH'(4);
                tag_pc <= pc;
                tag_epoch <= epoch;
            end
            if (PCsrc) begin
                pc <= branch_target & ~DATA_WIDTH'(3);
                epoch <= ~epoch;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_next;
                count <= count + CW'(push) - CW'(pop);
                // head registers hold their last value once the queue drains
                if (pop && count > CW'(1)) begin
                    instr <= mem_instr[rd_next];
                    instr_pc <= mem_pc[rd_next];
                end else if (push && (count == '0 || (pop && count == CW'(1)))) begin
                    instr <= imem_rdata;
                    instr_pc <= tag_pc;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push && !PCsrc) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr] <= tag_pc;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_count <= '0;
        else if (PCsrc && (count != '0 || inflight) && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
    end
`endif
endmodule
